// File: rtl/fetch_pc_unit_pkg.sv
// ============================================================================
// Module : fetch_pc_unit_pkg
// Brief  : Shared FSM encodings, reset defaults and helpers for the fetch unit
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pc_unit_pkg;

  localparam logic [1:0]  FETCH_BOOT       = 2'd0;
  localparam logic [1:0]  FETCH_REQ        = 2'd1;
  localparam logic [1:0]  FETCH_KILL       = 2'd2;
  localparam logic [1:0]  FETCH_HOLD       = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  // Targets are forced to a word boundary; low bits only feed the misaligned flag.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
// Module : fetch_pc_unit_if
// Brief  : Instruction-memory, decode and redirect signals of the fetch unit
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output instr_valid, instr, instr_pc, pc_plus4,
    input  instr_ready, stall,
    input  redirect_valid, redirect_pc,
    output misaligned
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  instr_valid, instr, instr_pc, pc_plus4,
    output instr_ready, stall,
    output redirect_valid, redirect_pc,
    input  misaligned
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit_adder.sv
// ============================================================================
// Module : fetch_pc_unit_adder
// Brief  : 32-bit adder used to form PC+4 (wraps modulo 2^32)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a + b;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module : fetch_pc_unit
// Brief  : PC register, single-outstanding imem fetch and decode handoff
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_pc_unit_if.master        bus
);

  localparam logic [31:0] c_pc_step = 32'd4;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_kill_addr;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_pc_plus4;
  logic        r_instr_valid;
  logic        r_misaligned;

  logic [31:0] w_pc_next;
  logic [31:0] w_redirect_pc;
  logic        w_consume;

  fetch_pc_unit_adder u_adder (
    .a (r_pc),
    .b (c_pc_step),
    .y (w_pc_next)
  );

  assign w_redirect_pc = align_word(bus.redirect_pc);
  assign w_consume     = bus.instr_ready & ~bus.stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= FETCH_BOOT;
      r_pc          <= align_word(RESET_PC);
      r_kill_addr   <= align_word(RESET_PC);
      r_instr       <= INSTR_NOP;
      r_instr_pc    <= 32'h0;
      r_pc_plus4    <= 32'h0;
      r_instr_valid <= 1'b0;
      r_misaligned  <= 1'b0;
    end else begin
      r_misaligned <= bus.redirect_valid & (|bus.redirect_pc[1:0]);
      case (r_state)
        FETCH_BOOT: begin
          if (bus.redirect_valid) r_pc <= w_redirect_pc;
          r_state <= FETCH_REQ;
        end
        FETCH_REQ: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (bus.imem_ready) begin
              r_state <= FETCH_REQ;
            end else begin
              // Keep presenting the in-flight address until memory accepts it.
              r_kill_addr <= r_pc;
              r_state     <= FETCH_KILL;
            end
          end else if (bus.imem_ready) begin
            r_instr       <= bus.imem_rdata;
            r_instr_pc    <= r_pc;
            r_pc_plus4    <= w_pc_next;
            r_pc          <= w_pc_next;
            r_instr_valid <= 1'b1;
            r_state       <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (bus.redirect_valid) begin
            r_pc          <= w_redirect_pc;
            r_instr_valid <= 1'b0;
            r_state       <= FETCH_REQ;
          end else if (w_consume) begin
            r_instr_valid <= 1'b0;
            r_state       <= FETCH_REQ;
          end
        end
        FETCH_KILL: begin
          if (bus.redirect_valid) r_pc <= w_redirect_pc;
          if (bus.imem_ready) r_state <= FETCH_REQ;
        end
        default: r_state <= FETCH_BOOT;
      endcase
    end
  end

  assign bus.imem_req    = (r_state == FETCH_REQ) || (r_state == FETCH_KILL);
  assign bus.imem_addr   = (r_state == FETCH_KILL) ? r_kill_addr : r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.pc_plus4    = r_pc_plus4;
  assign bus.misaligned  = r_misaligned;

endmodule

`default_nettype wire
